runlight_sched: RTL and testbench
=================================

# runlight_sched

Playlist scheduler for the 8-LED running-light pattern engine. It holds a small programmable playlist of (pattern mode, repeat count) slots and steps through them in order. For each slot it issues a start pulse and the mode code to the engine, and supplies the engine's step-rate tick. It counts the engine's completion pulses and advances to the next slot, wrapping at the end, until `run` is dropped.

## Interface
Parameters:
- `CLK_DIV`, default 4: clocks per `eng_step` tick. Must be ≥ 2.
- `NUM_SLOTS`, default 4: playlist depth. Must be a power of 2, ≥ 2.

Ports:
- `clk` in 1: clock.
- `reset` in 1: asynchronous, active-high.
- `cfg_we` in 1: playlist write strobe.
- `cfg_addr` in log2(NUM_SLOTS): slot to write.
- `cfg_mode` in 3: pattern mode code for the slot.
- `cfg_reps` in 4: repeat count for the slot. 0 means skip the slot.
- `run` in 1: level. High = play the playlist. Low = stop/abort.
- `pause` in 1: level. Freezes the step tick.
- `eng_done` in 1: one-cycle pulse from the engine when its pattern completes.
- `eng_start` out 1: one-cycle pulse to load `eng_mode` into the engine.
- `eng_mode` out 3: mode code for the engine. Held stable from `eng_start` until the next `eng_start`.
- `eng_step` out 1: one-cycle step tick.
- `eng_abort` out 1: one-cycle pulse when playback is stopped by `run` going low.
- `active` out 1: high in every state except IDLE.
- `slot_idx` out log2(NUM_SLOTS): slot currently playing or being scanned.
- `empty_err` out 1: sticky. Set when a scan finds no slot with reps ≠ 0. Cleared when the next playback begins.

## Operation
- Reset values:
  - All outputs 0.
  - State IDLE, prescaler 0, rep counter 0.
  - Playlist slot i = {mode = i[2:0], reps = 1}.
- Playlist writes:
  - Accepted in any state.
  - A write takes effect when that slot is next loaded by SCAN. The slot currently playing keeps its latched mode and repeat count.
- FSM states: IDLE, SCAN, START, RUN.
- IDLE:
  - `run` = 1 → SCAN, with `slot_idx` = 0, scan counter = 0, and `empty_err` cleared.
- SCAN (one slot examined per cycle):
  - reps[slot_idx] ≠ 0 → latch mode and reps into `eng_mode` and the rep counter, then → START.
  - Otherwise `slot_idx` = slot_idx + 1 (mod NUM_SLOTS) and the scan counter increments.
  - After NUM_SLOTS consecutive empty slots → set `empty_err`, → IDLE.
- START:
  - `eng_start` = 1 for this one cycle.
  - Prescaler cleared to 0.
  - → RUN.
- RUN:
  - The prescaler counts 0..CLK_DIV-1 while `pause` = 0. It holds its value while `pause` = 1.
  - `eng_step` = 1 in the cycle where the count equals CLK_DIV-1 and `pause` = 0.
  - On `eng_done` with rep counter > 1: decrement the counter, → START (same mode).
  - On `eng_done` with rep counter = 1: `slot_idx` + 1 (mod NUM_SLOTS), reset the scan counter, → SCAN.
- `run` = 0 in SCAN, START or RUN:
  - → IDLE next cycle, with `eng_abort` = 1 for one cycle.
  - `slot_idx` and `eng_mode` are held.
- Simultaneous events:
  - `eng_done` and `run` = 0 in the same cycle: abort wins.
  - `eng_done` outside RUN: ignored.
  - `cfg_we` to the slot being examined in SCAN in the same cycle: SCAN uses the old contents.

## Timing
- `run` rising with slot 0 valid:
  - `run` sampled high in IDLE at cycle 0.
  - SCAN at cycle 1.
  - START at cycle 2 (`eng_start` high).
  - First `eng_step` at cycle 2 + CLK_DIV.
- `eng_done` to next action:
  - Repeat of the same slot: `eng_start` 1 cycle after `eng_done`.
  - Advance to the next slot: `eng_start` 2 + k cycles after `eng_done`, where k = number of skipped empty slots.
- `eng_step` period is exactly CLK_DIV cycles when unpaused. Pause stretches the period by the number of paused cycles.
- Abort latency: 1 cycle from sampling `run` = 0.

## Structure
- Shared package `runlight_pkg` holds:
  - Mode codes: MODE_FILL = 0, MODE_MIRROR = 1, MODE_WALK = 2, MODE_PAIR = 3.
  - FSM state encoding.
  - Slot entry width (7 bits: mode[2:0], reps[3:0]).
- Sub-module `runlight_prescaler` implements the CLK_DIV counter with clear, hold (pause) and tick output.
- The playlist is a flop array; no RAM macro.

## Test plan
- Reset-default playlist, CLK_DIV = 4, `run` held high, engine model returns `eng_done` 10 steps after each start → `eng_mode` sequence 0, 1, 2, 3, 0, with `eng_start` 2 cycles after each `eng_done`.
- Slot 1 written reps = 3, slot 2 reps = 0 → modes 0, 1, 1, 1, 3. Repeats restart 1 cycle after `eng_done`. The skip costs +1 cycle.
- All slots written reps = 0, `run` raised → `empty_err` = 1 after NUM_SLOTS + 1 cycles, back to IDLE, `eng_start` never pulses.
- `pause` held 5 cycles mid-RUN → exactly one `eng_step` interval measures CLK_DIV + 5 cycles. The prescaler count is preserved across the pause.
- `run` dropped in the same cycle as `eng_done` → `eng_abort` pulse, no `eng_start`, `active` = 0 next cycle, `slot_idx` unchanged.
- `reset` asserted mid-RUN → all outputs 0 asynchronously, playlist restored to defaults, and a restart plays mode 0 first.

Source files
------------

// File: rtl/runlight_pkg.sv
// Shared types and constants for the running-light playlist scheduler.
// Slot entries pack a 3-bit mode code with a 4-bit repeat count.
package runlight_pkg;

   localparam int SLOT_W = 7;

   localparam logic [2:0] MODE_FILL   = 3'd0;
   localparam logic [2:0] MODE_MIRROR = 3'd1;
   localparam logic [2:0] MODE_WALK   = 3'd2;
   localparam logic [2:0] MODE_PAIR   = 3'd3;

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_START,
      S_RUN
   } state_t;

   typedef struct packed {
      logic [2:0] mode;
      logic [3:0] reps;
   } slot_t;

   function automatic slot_t slot_default(input int i);
      return '{mode: 3'(i), reps: 4'd1};
   endfunction

endpackage

// File: rtl/runlight_prescaler.sv
// Step-rate divider: counts 0..CLK_DIV-1 while enabled, holds otherwise.
// Tick fires on the last count of each period while enabled.
module runlight_prescaler #(
   parameter int CLK_DIV = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int CW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

   logic [CW-1:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear) begin
         count <= '0;
      end else if (enable) begin
         count <= (count == LAST) ? '0 : count + 1'b1;
      end
   end

   assign tick = enable && (count == LAST);

endmodule

// File: rtl/runlight_sched.sv
// Playlist scheduler: walks (mode, reps) slots, starts the pattern engine
// for each repeat and supplies its step tick until run drops.
module runlight_sched
   import runlight_pkg::*;
#(
   parameter int CLK_DIV = 4,
   parameter int NUM_SLOTS = 4,
   localparam int AW = $clog2(NUM_SLOTS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          cfg_we,
   input  logic [AW-1:0] cfg_addr,
   input  logic [2:0]    cfg_mode,
   input  logic [3:0]    cfg_reps,
   input  logic          run,
   input  logic          pause,
   input  logic          eng_done,
   output logic          eng_start,
   output logic [2:0]    eng_mode,
   output logic          eng_step,
   output logic          eng_abort,
   output logic          active,
   output logic [AW-1:0] slot_idx,
   output logic          empty_err
);

   localparam logic [AW-1:0] LAST_SLOT = AW'(NUM_SLOTS - 1);

   state_t        state;
   slot_t         list [NUM_SLOTS];
   slot_t         cur;
   logic [AW-1:0] scan_cnt;
   logic [3:0]    reps_cnt;

   // SCAN reads the pre-write contents when a write hits the same slot.
   assign cur = list[slot_idx];

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NUM_SLOTS; i++) begin
            list[i] <= slot_default(i);
         end
      end else if (cfg_we) begin
         list[cfg_addr] <= '{mode: cfg_mode, reps: cfg_reps};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         slot_idx  <= '0;
         scan_cnt  <= '0;
         reps_cnt  <= '0;
         eng_mode  <= '0;
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         empty_err <= 1'b0;
      end else begin
         eng_start <= 1'b0;
         eng_abort <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (run) begin
                  state     <= S_SCAN;
                  slot_idx  <= '0;
                  scan_cnt  <= '0;
                  empty_err <= 1'b0;
               end
            end
            S_SCAN: begin
               if (!run) begin
                  state     <= S_IDLE;
                  eng_abort <= 1'b1;
               end else if (cur.reps != 4'd0) begin
                  eng_mode  <= cur.mode;
                  reps_cnt  <= cur.reps;
                  eng_start <= 1'b1;
                  state     <= S_START;
               end else begin
                  slot_idx <= slot_idx + 1'b1;
                  if (scan_cnt == LAST_SLOT) begin
                     empty_err <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     scan_cnt <= scan_cnt + 1'b1;
                  end
               end
            end
            S_START: begin
               if (!run) begin
                  state     <= S_IDLE;
                  eng_abort <= 1'b1;
               end else begin
                  state <= S_RUN;
               end
            end
            S_RUN: begin
               if (!run) begin
                  state     <= S_IDLE;
                  eng_abort <= 1'b1;
               end else if (eng_done) begin
                  if (reps_cnt > 4'd1) begin
                     reps_cnt  <= reps_cnt - 4'd1;
                     eng_start <= 1'b1;
                     state     <= S_START;
                  end else begin
                     slot_idx <= slot_idx + 1'b1;
                     scan_cnt <= '0;
                     state    <= S_SCAN;
                  end
               end
            end
         endcase
      end
   end

   assign active = (state != S_IDLE);

   runlight_prescaler #(
      .CLK_DIV(CLK_DIV)
   ) u_presc (
      .clk   (clk),
      .reset (reset),
      .clear (state == S_START),
      .enable((state == S_RUN) && !pause),
      .tick  (eng_step)
   );

endmodule

// File: tb/tb_runlight_sched.sv
// Scoreboard bench for runlight_sched: expected engine starts are queued
// by the stimulus and popped by a monitor whenever eng_start fires.
module tb_runlight_sched;
   import runlight_pkg::*;

   logic       clk, reset, cfg_we, run, pause, eng_done;
   logic [1:0] cfg_addr;
   logic [2:0] cfg_mode;
   logic [3:0] cfg_reps;
   logic       eng_start, eng_step, eng_abort, active, empty_err;
   logic [2:0] eng_mode;
   logic [1:0] slot_idx;
   logic       model_done, man_done, eng_en;

   int cyc, t0, ts, n_checks, n_fail;

   typedef struct {
      int rel;
      int mode;
   } exp_t;

   exp_t sb[$];
   exp_t e;
   int   step_q[$];
   int   st_exp[4];

   assign eng_done = model_done | man_done;

   runlight_sched #(
      .CLK_DIV  (4),
      .NUM_SLOTS(4)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .cfg_we   (cfg_we),
      .cfg_addr (cfg_addr),
      .cfg_mode (cfg_mode),
      .cfg_reps (cfg_reps),
      .run      (run),
      .pause    (pause),
      .eng_done (eng_done),
      .eng_start(eng_start),
      .eng_mode (eng_mode),
      .eng_step (eng_step),
      .eng_abort(eng_abort),
      .active   (active),
      .slot_idx (slot_idx),
      .empty_err(empty_err)
   );

   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   function automatic void check(string name, int act, int exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                  name, act, exp, cyc);
      end
   endfunction

   always @(negedge clk) begin
      if (!reset && eng_start) begin
         if (sb.size() == 0) begin
            check("unexpected_start", 1, 0);
         end else begin
            e = sb.pop_front();
            check("start_cycle", cyc - t0, e.rel);
            check("start_mode", int'(eng_mode), e.mode);
         end
      end
      if (!reset && eng_step) step_q.push_back(cyc);
   end

   // Engine model: completes a pattern on the 10th step after a start.
   initial begin
      int steps;
      bit busy;
      model_done = 0;
      steps = 0;
      busy = 0;
      forever begin
         @(negedge clk);
         model_done = 0;
         if (!active) begin
            busy = 0;
         end else if (eng_start) begin
            busy = eng_en;
            steps = 0;
         end else if (busy && eng_step) begin
            steps++;
            if (steps == 10) begin
               model_done = 1;
               busy = 0;
            end
         end
      end
   end

   task automatic push(int rel, int mode);
      exp_t x;
      x.rel = rel;
      x.mode = mode;
      sb.push_back(x);
   endtask

   task automatic wait_sb(int lim);
      int i;
      i = 0;
      while (sb.size() != 0 && i < lim) begin
         @(negedge clk);
         i++;
      end
      check("sb_drained", sb.size(), 0);
      sb.delete();
   endtask

   task automatic at_cyc(int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic wr(int a, int m, int r);
      @(negedge clk);
      cfg_we = 1;
      cfg_addr = 2'(a);
      cfg_mode = 3'(m);
      cfg_reps = 4'(r);
   endtask

   task automatic check_idle_outs(string tag);
      check({tag, "_start"}, int'(eng_start), 0);
      check({tag, "_mode"}, int'(eng_mode), 0);
      check({tag, "_step"}, int'(eng_step), 0);
      check({tag, "_abort"}, int'(eng_abort), 0);
      check({tag, "_active"}, int'(active), 0);
      check({tag, "_slot"}, int'(slot_idx), 0);
      check({tag, "_empty"}, int'(empty_err), 0);
   endtask

   initial begin
      reset = 0; run = 0; pause = 0; cfg_we = 0;
      cfg_addr = 0; cfg_mode = 0; cfg_reps = 0;
      man_done = 0; eng_en = 1;
      #1 reset = 1;
      #1 check_idle_outs("reset");
      repeat (2) @(negedge clk);
      reset = 0;
      @(negedge clk);

      // default playlist, advance costs 2 cycles
      t0 = cyc;
      run = 1;
      for (int n = 0; n < 5; n++) push(2 + 42 * n, n % 4);
      wait_sb(300);
      run = 0;
      @(negedge clk);
      check("t1_abort", int'(eng_abort), 1);
      check("t1_active", int'(active), 0);
      check("t1_slot", int'(slot_idx), 0);
      @(negedge clk);
      check("t1_abort_len", int'(eng_abort), 0);

      // repeats and a skipped slot
      wr(1, MODE_MIRROR, 3);
      wr(2, MODE_WALK, 0);
      @(negedge clk);
      cfg_we = 0;
      t0 = cyc;
      run = 1;
      push(2, MODE_FILL);
      push(44, MODE_MIRROR);
      push(85, MODE_MIRROR);
      push(126, MODE_MIRROR);
      push(169, MODE_PAIR);
      wait_sb(300);
      run = 0;
      @(negedge clk);
      check("t2_abort", int'(eng_abort), 1);
      check("t2_slot", int'(slot_idx), 3);

      // all slots empty
      for (int i = 0; i < 4; i++) wr(i, i, 0);
      @(negedge clk);
      cfg_we = 0;
      t0 = cyc;
      run = 1;
      repeat (4) @(negedge clk);
      check("t3_scan_active", int'(active), 1);
      check("t3_scan_empty", int'(empty_err), 0);
      @(negedge clk);
      check("t3_empty", int'(empty_err), 1);
      check("t3_idle", int'(active), 0);
      check("t3_no_abort", int'(eng_abort), 0);
      run = 0;
      repeat (3) @(negedge clk);
      check("t3_sticky", int'(empty_err), 1);

      // pause stretches one step interval; only slot 2 valid
      eng_en = 0;
      wr(2, MODE_PAIR, 1);
      @(negedge clk);
      cfg_we = 0;
      t0 = cyc;
      run = 1;
      step_q.delete();
      push(4, MODE_PAIR);
      @(negedge clk);
      check("t4_err_clear", int'(empty_err), 0);
      ts = t0 + 4;
      at_cyc(ts + 10);
      pause = 1;
      at_cyc(ts + 15);
      pause = 0;
      at_cyc(ts + 23);
      st_exp = '{4, 8, 17, 21};
      check("t4_step_count", step_q.size(), 4);
      for (int i = 0; i < 4; i++) begin
         check("t4_step_time", (i < step_q.size()) ? step_q[i] - ts : -1,
               st_exp[i]);
      end
      wait_sb(5);

      // abort beats a simultaneous eng_done
      at_cyc(ts + 24);
      man_done = 1;
      run = 0;
      @(negedge clk);
      man_done = 0;
      check("t5_abort", int'(eng_abort), 1);
      check("t5_active", int'(active), 0);
      check("t5_slot", int'(slot_idx), 2);
      check("t5_mode", int'(eng_mode), 3);
      repeat (4) @(negedge clk);
      check("t5_stay_idle", int'(active), 0);

      // asynchronous reset mid-RUN restores the default playlist
      eng_en = 1;
      t0 = cyc;
      run = 1;
      push(4, MODE_PAIR);
      wait_sb(20);
      at_cyc(t0 + 9);
      check("t6_running", int'(active), 1);
      #1 reset = 1;
      #1 check_idle_outs("t6_reset");
      @(negedge clk);
      @(negedge clk);
      reset = 0;
      t0 = cyc;
      push(2, MODE_FILL);
      push(44, MODE_MIRROR);
      wait_sb(100);
      run = 0;
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
